// File: rtl/ccd_capture_ctrl.sv
// ============================================================================
// ccd_capture_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Front-end capture stage between the CMOS sensor pins and the Bayer-to-RGB
//   stage. The block registers raw pixel data and the frame/line valid
//   strobes. Capture is gated by start/stop pulses, and gating only changes at
//   frame boundaries, so a partial frame is never emitted. The block outputs a
//   pixel-valid strobe, X/Y coordinates of each pixel and a completed-frame
//   counter.
//
// Parameters:
//   DATA_W  raw pixel width
//   CNT_W   width of the X/Y coordinate counters
//   X_MAX   active pixels per line; X wraps to 0 after X_MAX-1 and Y advances
//
// Ports:
//   iCLK         in   1       pixel clock, rising edge
//   iRST         in   1       asynchronous active-high reset
//   iDATA        in   DATA_W  sensor pixel data
//   iFVAL        in   1       sensor frame valid
//   iLVAL        in   1       sensor line valid
//   iSTART       in   1       one-cycle pulse: arm capture (ignored unless idle)
//   iSTOP        in   1       one-cycle pulse: stop at end of current frame
//   oDATA        out  DATA_W  captured pixel (iDATA delayed by 2 cycles)
//   oDVAL        out  1       oDATA / oX_Cont / oY_Cont valid this cycle
//   oX_Cont      out  CNT_W   column of oDATA
//   oY_Cont      out  CNT_W   row of oDATA
//   oFrame_Cont  out  32      frames completed while capturing, since reset
//   oBusy        out  1       high whenever the controller is not idle
//
// Configuration macro:
//   CCD_CAPTURE_TEST_PATTERN_EN
//     Defined  : oDATA carries (X + Y) truncated to DATA_W instead of the
//                sensor data. Timing, oDVAL and all counters are unchanged.
//     Undefined: oDATA carries the registered sensor data.
// ============================================================================
module ccd_capture_ctrl #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16,
    parameter int X_MAX  = 1280
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iSTART,
    input  logic              iSTOP,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [31:0]       oFrame_Cont,
    output logic              oBusy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        IN_FRAME = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_MAX - 1);

    // ------------------------------------------------------------------
    // Stage 1: sensor input registers (f2_q is a second delay of FVAL
    // used only for edge detection).
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] d1_q;
    logic              f1_q;
    logic              f2_q;
    logic              l1_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            d1_q <= '0;
            f1_q <= 1'b0;
            f2_q <= 1'b0;
            l1_q <= 1'b0;
        end else begin
            d1_q <= iDATA;
            f1_q <= iFVAL;
            f2_q <= f1_q;
            l1_q <= iLVAL;
        end
    end

    logic sof;
    logic eof;

    assign sof = f1_q & ~f2_q;
    assign eof = ~f1_q & f2_q;

    // ------------------------------------------------------------------
    // Capture control FSM
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic        stop_pend_q;
    logic        stop_pend_d;
    logic [31:0] frame_q;
    logic [31:0] frame_d;
    logic        start_frame;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            frame_q     <= frame_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        frame_d     = frame_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                // Stop wins over a simultaneous start; a lone stop is ignored.
                if (iSTART && !iSTOP) begin
                    state_d = WAIT_SOF;
                end
            end

            WAIT_SOF: begin
                // Nothing is in flight yet, so a stop takes effect at once.
                // The pending flag would be consumed on the same transition,
                // so it is left clear.
                if (iSTOP) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (sof) begin
                    state_d     = IN_FRAME;
                    start_frame = 1'b1;
                end
            end

            IN_FRAME: begin
                if (iSTOP) begin
                    stop_pend_d = 1'b1;
                end
                if (eof) begin
                    frame_d = frame_q + 32'd1;
                    // A stop landing on the EOF cycle itself still counts.
                    if (stop_pend_q || iSTOP) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        // Straight back to waiting so that an SOF on the very
                        // next cycle (1-cycle FVAL gap) is still caught.
                        state_d = WAIT_SOF;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Coordinate counters and output stage
    // ------------------------------------------------------------------
    logic              pv;
    logic [CNT_W-1:0]  x_q;
    logic [CNT_W-1:0]  x_d;
    logic [CNT_W-1:0]  y_q;
    logic [CNT_W-1:0]  y_d;
    logic [CNT_W-1:0]  xo_q;
    logic [CNT_W-1:0]  xo_d;
    logic [CNT_W-1:0]  yo_q;
    logic [CNT_W-1:0]  yo_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              dval_q;

    // LVAL while FVAL is low never qualifies, so stray line strobes between
    // frames cannot produce pixels.
    assign pv = f1_q & l1_q & (state_q == IN_FRAME);

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        xo_d = xo_q;
        yo_d = yo_q;

        if (!l1_q) begin
            // Between lines: column restarts, row is kept. A line shorter
            // than X_MAX therefore does not advance the row.
            x_d = '0;
        end else if (pv) begin
            xo_d = x_q;
            yo_d = y_q;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end

        if (start_frame) begin
            x_d = '0;
            y_d = '0;
        end
    end

`ifdef CCD_CAPTURE_TEST_PATTERN_EN
    // Synthetic diagonal ramp; sensor data is not used.
    assign data_d = DATA_W'(x_q + y_q);
`else
    assign data_d = d1_q;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_q    <= '0;
            y_q    <= '0;
            xo_q   <= '0;
            yo_q   <= '0;
            data_q <= '0;
            dval_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            xo_q   <= xo_d;
            yo_q   <= yo_d;
            data_q <= data_d;
            dval_q <= pv;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = xo_q;
    assign oY_Cont     = yo_q;
    assign oFrame_Cont = frame_q;
    assign oBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// ============================================================================
// tb_ccd_capture_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for ccd_capture_ctrl with X_MAX = 4. Directed scenarios
// cover reset, basic frame, mid-frame arming, stop, simultaneous start/stop,
// a short line and back-to-back frames. A randomized section then drives
// random frames, control pulses and resets. Every cycle is compared against a
// behavioural model: pixel coordinates are derived from a count of pixels in
// the current line, and capture gating follows the frame-level arm/stop rules.
// ============================================================================
module tb_ccd_capture_ctrl;

    localparam int DW = 10;
    localparam int CW = 16;
    localparam int XM = 4;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [DW-1:0] iDATA;
    logic          iFVAL;
    logic          iLVAL;
    logic          iSTART;
    logic          iSTOP;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic [CW-1:0] oX_Cont;
    logic [CW-1:0] oY_Cont;
    logic [31:0]   oFrame_Cont;
    logic          oBusy;

    ccd_capture_ctrl #(.DATA_W(DW), .CNT_W(CW), .X_MAX(XM)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iDATA       (iDATA),
        .iFVAL       (iFVAL),
        .iLVAL       (iLVAL),
        .iSTART      (iSTART),
        .iSTOP       (iSTOP),
        .oDATA       (oDATA),
        .oDVAL       (oDVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oBusy       (oBusy)
    );

    always #5 iCLK = ~iCLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_d1;
    logic          m_f1, m_f2, m_l1;
    int            m_mode;     // 0 idle, 1 armed, 2 capturing
    bit            m_pend;
    int            m_run;      // pixels captured in the current line run
    int            m_rows;     // rows completed in this frame before this line
    logic [31:0]   m_frames;

    logic [DW-1:0] e_data;
    logic          e_dval;
    logic [CW-1:0] e_x, e_y;
    logic          e_busy;

    task automatic model_reset();
        m_d1 = '0; m_f1 = 0; m_f2 = 0; m_l1 = 0;
        m_mode = 0; m_pend = 0; m_run = 0; m_rows = 0; m_frames = '0;
        e_data = '0; e_dval = 0; e_x = '0; e_y = '0; e_busy = 0;
    endtask

    task automatic model_step(input logic f, input logic l, input logic [DW-1:0] d,
                              input logic st, input logic sp, input logic rs);
        bit sof, eof, pv;
        if (rs) begin
            model_reset();
            return;
        end
        sof = m_f1 && !m_f2;
        eof = !m_f1 && m_f2;
        pv  = m_f1 && m_l1 && (m_mode == 2);

        e_dval = pv;
        e_data = m_d1;
        if (pv) begin
            e_x = CW'(m_run % XM);
            e_y = CW'(m_rows + m_run / XM);
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
            e_data = DW'(e_x + e_y);
`endif
            m_run++;
        end else if (!m_l1) begin
            m_rows += m_run / XM;
            m_run   = 0;
        end

        case (m_mode)
            0: if (st && !sp) m_mode = 1;
            1: begin
                if (sp) m_mode = 0;
                else if (sof) begin
                    m_mode = 2;
                    m_run  = 0;
                    m_rows = 0;
                end
            end
            default: begin
                if (sp) m_pend = 1;
                if (eof) begin
                    m_frames = m_frames + 32'd1;
                    if (m_pend) begin
                        m_mode = 0;
                        m_pend = 0;
                    end else begin
                        m_mode = 1;
                    end
                end
            end
        endcase
        e_busy = (m_mode != 0);

        m_f2 = m_f1;
        m_f1 = f;
        m_l1 = l;
        m_d1 = d;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int dv_cnt;
    int first_x, first_y, last_x, last_y;
    int g_idx, g_start_at, g_stop_at, g_rst_at, g_short_idx;
    bit g_noise;

    task automatic cyc(input logic f, input logic l, input logic [DW-1:0] d,
                       input logic st, input logic sp, input logic rs);
        iFVAL  = f;
        iLVAL  = l;
        iDATA  = d;
        iSTART = st;
        iSTOP  = sp;
        iRST   = rs;
        model_step(f, l, d, st, sp, rs);
        @(posedge iCLK);
        @(negedge iCLK);
        check_eq("dval",  32'(oDVAL),  32'(e_dval));
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
        if (e_dval) check_eq("data", 32'(oDATA), 32'(e_data));
`else
        check_eq("data",  32'(oDATA),  32'(e_data));
`endif
        check_eq("x",     32'(oX_Cont), 32'(e_x));
        check_eq("y",     32'(oY_Cont), 32'(e_y));
        check_eq("frame", oFrame_Cont,  e_frames_w());
        check_eq("busy",  32'(oBusy),   32'(e_busy));
        if (oDVAL === 1'b1) begin
            if (dv_cnt == 0) begin
                first_x = int'(oX_Cont);
                first_y = int'(oY_Cont);
            end
            last_x = int'(oX_Cont);
            last_y = int'(oY_Cont);
            dv_cnt++;
        end
    endtask

    function automatic logic [31:0] e_frames_w();
        return m_frames;
    endfunction

    task automatic fcyc(input logic f, input logic l);
        cyc(f, l, DW'($urandom), 1'(g_idx == g_start_at), 1'(g_idx == g_stop_at),
            1'(g_idx == g_rst_at));
        g_idx++;
    endtask

    task automatic clear_ctl();
        g_start_at = -1; g_stop_at = -1; g_rst_at = -1; g_short_idx = -1; g_noise = 0;
    endtask

    task automatic idle_cyc(input logic st, input logic sp);
        cyc(1'b0, 1'b0, DW'($urandom), st, sp, 1'b0);
    endtask

    // One lead cycle with FVAL only, then lines of LVAL separated by one
    // blank cycle, then `gap` cycles with FVAL low.
    task automatic send_frame(input int nlines, input int len, input int gap);
        g_idx = 0;
        fcyc(1'b1, 1'b0);
        for (int ln = 0; ln < nlines; ln++) begin
            int n;
            n = (ln == g_short_idx) ? 2 : len;
            repeat (n) fcyc(1'b1, 1'b1);
            fcyc(1'b1, 1'b0);
        end
        repeat (gap) fcyc(1'b0, g_noise ? 1'($urandom) : 1'b0);
    endtask

    task automatic reset_counts();
        dv_cnt = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b1; iFVAL = 0; iLVAL = 0; iDATA = '0; iSTART = 0; iSTOP = 0;
        model_reset();
        clear_ctl();
        reset_counts();
        @(negedge iCLK);

        // Reset held while the sensor toggles
        repeat (6) cyc(1'($urandom), 1'($urandom), DW'($urandom), 1'($urandom), 1'b0, 1'b1);
        check_eq("rst_dval",  32'(oDVAL), 32'd0);
        check_eq("rst_busy",  32'(oBusy), 32'd0);
        check_eq("rst_frame", oFrame_Cont, 32'd0);
        check_eq("rst_data",  32'(oDATA), 32'd0);

        // No capture without a start pulse
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("nostart_dv", 32'(dv_cnt), 32'd0);

        // Basic frame: 3 lines of 4 pixels
        idle_cyc(1'b1, 1'b0);
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("basic_dv",    32'(dv_cnt),  32'd12);
        check_eq("basic_fx",    32'(first_x), 32'd0);
        check_eq("basic_fy",    32'(first_y), 32'd0);
        check_eq("basic_lx",    32'(last_x),  32'd3);
        check_eq("basic_ly",    32'(last_y),  32'd2);
        check_eq("basic_frame", oFrame_Cont,  32'd1);
        check_eq("basic_busy",  32'(oBusy),   32'd1);

        // Start and stop together while waiting for SOF: back to idle
        idle_cyc(1'b1, 1'b1);
        check_eq("ss_busy", 32'(oBusy), 32'd0);

        // Armed mid-frame: that frame is skipped, next one starts at (0,0)
        clear_ctl();
        g_start_at = 6;
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("mid_dv",   32'(dv_cnt), 32'd0);
        check_eq("mid_busy", 32'(oBusy),  32'd1);
        clear_ctl();
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("mid2_dv",    32'(dv_cnt),  32'd12);
        check_eq("mid2_fx",    32'(first_x), 32'd0);
        check_eq("mid2_fy",    32'(first_y), 32'd0);
        check_eq("mid2_frame", oFrame_Cont,  32'd2);

        // Stop mid-frame: frame completes, then idle
        g_stop_at = 5;
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("stop_dv",    32'(dv_cnt), 32'd12);
        check_eq("stop_frame", oFrame_Cont, 32'd3);
        check_eq("stop_busy",  32'(oBusy),  32'd0);
        clear_ctl();
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("after_stop_dv",    32'(dv_cnt), 32'd0);
        check_eq("after_stop_frame", oFrame_Cont, 32'd3);

        // Short middle line: Y does not advance, next line restarts at X=0
        idle_cyc(1'b1, 1'b0);
        g_short_idx = 1;
        reset_counts();
        send_frame(3, 4, 3);
        check_eq("short_dv", 32'(dv_cnt), 32'd10);
        check_eq("short_lx", 32'(last_x), 32'd3);
        check_eq("short_ly", 32'(last_y), 32'd1);
        clear_ctl();

        // FVAL low for a single cycle between frames
        reset_counts();
        send_frame(2, 4, 1);
        send_frame(2, 4, 3);
        check_eq("adj_dv",    32'(dv_cnt), 32'd16);
        check_eq("adj_frame", oFrame_Cont, 32'd6);

        // Reset mid-frame, then capture needs a fresh start and SOF
        g_rst_at = 4;
        send_frame(3, 4, 3);
        check_eq("rstmid_frame", oFrame_Cont, 32'd0);
        check_eq("rstmid_busy",  32'(oBusy),  32'd0);
        clear_ctl();

        // Randomized frames, control pulses and resets
        for (int it = 0; it < 60; it++) begin
            int nl, ln, gp, tot;
            clear_ctl();
            nl = int'($urandom_range(1, 4));
            ln = int'($urandom_range(1, 7));
            gp = int'($urandom_range(1, 4));
            tot = 1 + nl * (ln + 1);
            g_noise = 1'($urandom);
            if ($urandom_range(0, 2) == 0) g_short_idx = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) g_start_at = int'($urandom_range(0, tot));
            if ($urandom_range(0, 5) == 0) g_stop_at  = int'($urandom_range(0, tot));
            if ($urandom_range(0, 9) == 0) g_rst_at   = int'($urandom_range(0, tot));
            if ($urandom_range(0, 2) == 0) idle_cyc(1'($urandom), 1'($urandom_range(0, 3) == 0));
            send_frame(nl, ln, gp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
